mem_access_ctrl: RTL

Sequencer for the multi-cycle core's hidden registers (MAR, IMDR, OMDR, IR) and the external memory bus. Accepts one fetch, load or store request at a time from the control unit, drives the hidden-register write enables and data in the correct order, runs a req/ack bus cycle with arbitrary wait states, and reports completion. Sits between the control-unit FSM, the hidden-register file and the memory port.

---
 rtl/mem_access_ctrl_if.sv | 39 +++
 rtl/mem_access_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl_if.sv
// Memory-port bundle between the hidden-register access sequencer and external memory.
// Latency: none, wires only; the master drives request/address/data, the slave answers.
// Backpressure: the slave stalls by withholding mem_ack_i; the master holds its request.
interface mem_access_ctrl_if #(
    parameter int WORD = 16
);

    // Request side, driven by the sequencer
    logic              mem_req_o;
    logic              mem_we_o;
    logic [1:0]        mem_be_o;
    logic [WORD-1:0]   mem_addr_o;
    logic [WORD-1:0]   mem_wdata_o;

    // Response side, driven by the memory
    logic              mem_ack_i;
    logic [WORD-1:0]   mem_rdata_i;

    modport master (
        output mem_req_o,
        output mem_we_o,
        output mem_be_o,
        output mem_addr_o,
        output mem_wdata_o,
        input  mem_ack_i,
        input  mem_rdata_i
    );

    modport slave (
        input  mem_req_o,
        input  mem_we_o,
        input  mem_be_o,
        input  mem_addr_o,
        input  mem_wdata_o,
        output mem_ack_i,
        output mem_rdata_i
    );

endinterface

// File: rtl/mem_access_ctrl.sv
// Sequencer for MAR/OMDR/IMDR/IR writes and one req/ack memory cycle per fetch/load/store.
// Latency: strobe -> done_o is 3 cycles plus wait states; misaligned requests finish next cycle.
// Backpressure: busy_o high outside IDLE, strobes ignored then; bus waits held until mem_ack_i.
// Optional bus-wait timeout is enabled by defining MEM_TIMEOUT_EN (TIMEOUT cycles of req).
module mem_access_ctrl #(
    parameter int WORD    = 16,
    parameter int TIMEOUT = 15
) (
    input  logic               clk_i,
    input  logic               rst_i,

    // Control-unit request side
    input  logic               fetch_i,
    input  logic               load_i,
    input  logic               store_i,
    input  logic               byte_i,
    input  logic [WORD-1:0]    addr_i,
    input  logic [WORD-1:0]    wdata_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o,

    // Hidden-register file side
    output logic               MARwr_o,
    output logic               OMDRwr_o,
    output logic               IMDRwr_o,
    output logic               IRwr_o,
    output logic [WORD-1:0]    MARdat_o,
    output logic [WORD-1:0]    OMDRdat_o,
    output logic [WORD-1:0]    IMDRdat_o,
    output logic [WORD-1:0]    IRdat_o,
    input  logic [WORD-1:0]    MARq_i,
    input  logic [WORD-1:0]    OMDRq_i,

    // External memory port
    mem_access_ctrl_if.master  mem_bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LATCH = 2'd1,
        S_BUS   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OP_FETCH = 2'd0,
        OP_LOAD  = 2'd1,
        OP_STORE = 2'd2
    } op_t;

    // Sequencer state and the request captured in IDLE
    state_t            state_q, state_d;
    op_t               op_q,    op_d;
    logic              byte_q,  byte_d;
    logic [WORD-1:0]   addr_q,  addr_d;
    logic              err_q,   err_d;

    // Alignment result of the request being accepted this cycle
    logic              misalign;

    // Byte lane picked from the read data for byte loads
    logic [7:0]        rd_byte;

`ifdef MEM_TIMEOUT_EN
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    // Cycles spent in BUS without an acknowledge
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              wait_expired;

    // Last permitted request cycle: an ack here still completes normally
    assign wait_expired = (cnt_q == CW'(TIMEOUT - 1));
`else
    // Without the timeout the limit parameter has no function
    logic              unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
`endif

    // State and request registers; reset returns to IDLE so every output drops at once
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            op_q    <= OP_FETCH;
            byte_q  <= 1'b0;
            addr_q  <= '0;
            err_q   <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            byte_q  <= byte_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
`ifdef MEM_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    // Next-state logic: accept and check requests in IDLE, wait for ack in BUS
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        byte_d   = byte_q;
        addr_d   = addr_q;
        err_d    = err_q;
        misalign = 1'b0;
`ifdef MEM_TIMEOUT_EN
        cnt_d    = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (fetch_i || load_i || store_i) begin
                    // Fetch wins over load, load over store; fetches are always word-sized
                    if (fetch_i) begin
                        op_d   = OP_FETCH;
                        byte_d = 1'b0;
                    end else if (load_i) begin
                        op_d   = OP_LOAD;
                        byte_d = byte_i;
                    end else begin
                        op_d   = OP_STORE;
                        byte_d = byte_i;
                    end
                    // Only word accesses need even addresses
                    misalign = addr_i[0] & ~byte_d;
                    addr_d   = addr_i;
                    err_d    = misalign;
                    state_d  = misalign ? S_DONE : S_LATCH;
                end
            end

            S_LATCH: begin
                state_d = S_BUS;
`ifdef MEM_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end

            S_BUS: begin
                if (mem_bus.mem_ack_i) begin
                    state_d = S_DONE;
                end
`ifdef MEM_TIMEOUT_EN
                else if (wait_expired) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
`endif
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Read-data lane selection follows the latched low address bit
    assign rd_byte = addr_q[0] ? mem_bus.mem_rdata_i[15:8] : mem_bus.mem_rdata_i[7:0];

    // Output decode: every output is zero unless its state explicitly drives it
    always_comb begin
        busy_o              = (state_q != S_IDLE);
        done_o              = 1'b0;
        err_o               = 1'b0;
        MARwr_o             = 1'b0;
        OMDRwr_o            = 1'b0;
        IMDRwr_o            = 1'b0;
        IRwr_o              = 1'b0;
        MARdat_o            = '0;
        OMDRdat_o           = '0;
        IMDRdat_o           = '0;
        IRdat_o             = '0;
        mem_bus.mem_req_o   = 1'b0;
        mem_bus.mem_we_o    = 1'b0;
        mem_bus.mem_be_o    = 2'b00;
        mem_bus.mem_addr_o  = '0;
        mem_bus.mem_wdata_o = '0;

        case (state_q)
            S_LATCH: begin
                MARwr_o  = 1'b1;
                MARdat_o = addr_q;
                if (op_q == OP_STORE) begin
                    OMDRwr_o  = 1'b1;
                    // A byte store replicates the byte so either lane carries it
                    OMDRdat_o = byte_q ? {wdata_i[7:0], wdata_i[7:0]} : wdata_i;
                end
            end

            S_BUS: begin
                mem_bus.mem_req_o   = 1'b1;
                mem_bus.mem_we_o    = (op_q == OP_STORE);
                mem_bus.mem_be_o    = byte_q ? (addr_q[0] ? 2'b10 : 2'b01) : 2'b11;
                mem_bus.mem_addr_o  = MARq_i;
                mem_bus.mem_wdata_o = OMDRq_i;
                // Read data is captured at the same edge that samples the ack
                if (mem_bus.mem_ack_i && (op_q != OP_STORE)) begin
                    IMDRwr_o  = 1'b1;
                    IMDRdat_o = byte_q ? {{(WORD-8){1'b0}}, rd_byte} : mem_bus.mem_rdata_i;
                    if (op_q == OP_FETCH) begin
                        IRwr_o  = 1'b1;
                        IRdat_o = mem_bus.mem_rdata_i;
                    end
                end
            end

            S_DONE: begin
                done_o = 1'b1;
                err_o  = err_q;
            end

            default: begin
            end
        endcase
    end

endmodule
